// File: rtl/soc_pkg.sv
// Shared SoC constants: peripheral page, peripheral register offsets and bridge FSM states.
package soc_pkg;

    localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;

    localparam logic [11:0] OFS_SEG = 12'h000;
    localparam logic [11:0] OFS_LED = 12'h060;
    localparam logic [11:0] OFS_SW  = 12'h070;

    typedef enum logic {
        IDLE   = 1'b0,
        RDWAIT = 1'b1
    } bridge_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous active-high reset.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/io_bus_bridge.sv
// Routes CPU loads/stores to the synchronous data RAM or the on-board peripherals,
// stalling the CPU for one cycle on every RAM load.
module io_bus_bridge
    import soc_pkg::*;
#(
    parameter int          DRAM_AW     = 14,
    parameter logic [19:0] PERIPH_BASE = 20'hFFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IO_rd_e,
    input  logic               IO_wr_e,
    input  logic [31:0]        io_addr,
    input  logic [31:0]        io_wdata,
    output logic [31:0]        io_rdata,
    output logic               io_stall,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic [31:0]        dram_wdata,
    output logic               dram_we,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    output logic [23:0]        led,
    output logic [31:0]        seg_data,
    output bridge_state_t      dbg_state
);

    // Handshake: the CPU holds IO_rd_e/io_addr steady while io_stall is high; the load
    // completes in the cycle after the stall, when io_rdata carries the RAM word.

    bridge_state_t state_q, state_d;

    logic        periph;
    logic        wr;
    logic        rd;
    logic [9:0]  ofs_word;
    logic [23:0] sw_s;
    logic [31:0] periph_rdata;

    assign periph     = (io_addr[31:12] == PERIPH_BASE);
    assign wr         = IO_wr_e;
    assign rd         = IO_rd_e & ~IO_wr_e;
    assign ofs_word   = io_addr[11:2];
    assign dram_addr  = io_addr[DRAM_AW+1:2];
    assign dram_wdata = io_wdata;
    assign dram_we    = wr & ~periph & ~rst;
    assign dbg_state  = state_q;

    sync2 #(.W(24)) u_sw_sync (
        .clk (clk),
        .rst (rst),
        .d   (sw),
        .q   (sw_s)
    );

    // Only the switch register is readable; every other offset reads as zero.
    assign periph_rdata = (ofs_word == OFS_SW[11:2]) ? {8'h00, sw_s} : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            led      <= '0;
            seg_data <= '0;
        end else if (wr && periph) begin
            if (ofs_word == OFS_SEG[11:2]) seg_data <= io_wdata;
            if (ofs_word == OFS_LED[11:2]) led      <= io_wdata[23:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // RDWAIT never looks at the strobes, so the held load is not restarted.
    always_comb begin
        state_d  = state_q;
        io_stall = 1'b0;
        io_rdata = 32'h0;
        case (state_q)
            IDLE: begin
                if (!rst && rd && !periph) begin
                    io_stall = 1'b1;
                    state_d  = RDWAIT;
                end else if (!rst && rd && periph) begin
                    io_rdata = periph_rdata;
                end
            end
            RDWAIT: begin
                state_d = IDLE;
                if (!rst) io_rdata = dram_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Randomized bench for io_bus_bridge: a word-level memory/peripheral model predicts
// each cycle's outputs, which a negedge monitor compares against the DUT.
module tb_io_bus_bridge;
  import soc_pkg::*;

  localparam int AW = 14;
  localparam int W  = 1 + 1 + 1 + 32 + AW + 32 + 24 + 32;

  logic          clk;
  logic          rst;
  logic          IO_rd_e;
  logic          IO_wr_e;
  logic [31:0]   io_addr;
  logic [31:0]   io_wdata;
  logic [31:0]   io_rdata;
  logic          io_stall;
  logic [AW-1:0] dram_addr;
  logic [31:0]   dram_wdata;
  logic          dram_we;
  logic [31:0]   dram_rdata;
  logic [23:0]   sw;
  logic [23:0]   led;
  logic [31:0]   seg_data;
  bridge_state_t dbg_state;

  io_bus_bridge #(.DRAM_AW(AW), .PERIPH_BASE(20'hFFFFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .IO_rd_e    (IO_rd_e),
    .IO_wr_e    (IO_wr_e),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .io_stall   (io_stall),
    .dram_addr  (dram_addr),
    .dram_wdata (dram_wdata),
    .dram_we    (dram_we),
    .dram_rdata (dram_rdata),
    .sw         (sw),
    .led        (led),
    .seg_data   (seg_data),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- external synchronous RAM ----------------
  logic [31:0] ram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
    dram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (dram_we) ram[dram_addr] <= dram_wdata;
    dram_rdata <= ram[dram_addr];
  end

  // ---------------- reference model ----------------
  logic [31:0] m_mem [0:(1<<AW)-1];
  logic [23:0] m_led;
  logic [31:0] m_seg;
  logic [23:0] m_s1, m_s2;
  logic        m_pending;
  logic [31:0] m_pend_data;

  logic [W-1:0] exp_q[$];
  int checks;
  int failures;

  task automatic do_cycle(input logic r, input logic rd_e, input logic wr_e,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [23:0] s);
    logic        periph, is_rd, is_wr, exp_stall, exp_we;
    logic [9:0]  ofs;
    logic [AW-1:0] wa;
    logic [31:0] exp_rdata;
    rst = r; IO_rd_e = rd_e; IO_wr_e = wr_e; io_addr = a; io_wdata = wd; sw = s;
    periph    = (a[31:12] == 20'hFFFFF);
    ofs       = a[11:2];
    is_wr     = wr_e;
    is_rd     = rd_e && !wr_e;
    wa        = a[AW+1:2];
    exp_stall = !r && !m_pending && is_rd && !periph;
    exp_we    = !r && is_wr && !periph;
    exp_rdata = 32'h0;
    if (!r) begin
      if (m_pending) exp_rdata = m_pend_data;
      else if (is_rd && periph && ofs == 10'h01C) exp_rdata = {8'h00, m_s2};
    end
    exp_q.push_back({exp_stall, exp_we, m_pending, exp_rdata, wa, wd, m_led, m_seg});
    @(posedge clk);
    if (r) begin
      m_led = '0; m_seg = '0; m_s1 = '0; m_s2 = '0; m_pending = 1'b0;
    end else begin
      if (exp_stall) m_pend_data = m_mem[wa];
      if (exp_we) m_mem[wa] = wd;
      if (is_wr && periph && ofs == 10'h000) m_seg = wd;
      if (is_wr && periph && ofs == 10'h018) m_led = wd[23:0];
      m_s2 = m_s1;
      m_s1 = s;
      m_pending = exp_stall;
    end
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0]  e;
    logic          e_stall, e_we, e_st;
    logic [31:0]   e_rdata, e_wdata, e_seg;
    logic [AW-1:0] e_addr;
    logic [23:0]   e_led;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      {e_stall, e_we, e_st, e_rdata, e_addr, e_wdata, e_led, e_seg} = e;
      check("io_stall",   {31'h0, io_stall},        {31'h0, e_stall});
      check("dram_we",    {31'h0, dram_we},         {31'h0, e_we});
      check("dbg_state",  {31'h0, dbg_state == RDWAIT}, {31'h0, e_st});
      check("io_rdata",   io_rdata,                 e_rdata);
      check("dram_addr",  {{(32-AW){1'b0}}, dram_addr}, {{(32-AW){1'b0}}, e_addr});
      check("dram_wdata", dram_wdata,               e_wdata);
      check("led",        {8'h00, led},             {8'h00, e_led});
      check("seg_data",   seg_data,                 e_seg);
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] PB = 32'hFFFFF000;

  function automatic logic [31:0] dram_a(input int idx);
    logic [15:0] hi;
    logic [1:0]  lo;
    hi = 16'($urandom_range(0, 16'hFFFE));
    lo = 2'($urandom_range(0, 3));
    return {hi, 10'h000, 4'(idx), lo};
  endfunction

  logic        p_rd, p_wr;
  logic [31:0] p_a, p_wd;
  logic [23:0] cur_sw;

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = 32'h0;
    m_led = '0; m_seg = '0; m_s1 = '0; m_s2 = '0; m_pending = 1'b0; m_pend_data = '0;
    rst = 1'b1; IO_rd_e = 1'b0; IO_wr_e = 1'b0; io_addr = 32'h0; io_wdata = 32'h0; sw = '0;
    @(posedge clk); #1;

    do_cycle(1, 0, 0, 32'h0, 32'h0, 24'h0);
    do_cycle(1, 1, 0, 32'h0000_0040, 32'h0, 24'h0);

    // store to seg
    do_cycle(0, 1, 1, PB, 32'h1234_5678, 24'h0);
    do_cycle(0, 0, 0, 32'h0, 32'h0, 24'h0);
    // DRAM store then load
    do_cycle(0, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 24'h0);
    do_cycle(0, 1, 0, 32'h0000_0010, 32'h0, 24'h0);
    do_cycle(0, 1, 0, 32'h0000_0010, 32'h0, 24'h0);
    // switch read
    do_cycle(0, 0, 0, 32'h0, 32'h0, 24'hA5A5A5);
    do_cycle(0, 0, 0, 32'h0, 32'h0, 24'hA5A5A5);
    do_cycle(0, 1, 0, PB | 32'h070, 32'h0, 24'hA5A5A5);
    // both strobes
    do_cycle(0, 1, 1, PB | 32'h060, 32'hFFFF_FFFF, 24'hA5A5A5);
    do_cycle(0, 0, 0, 32'h0, 32'h0, 24'hA5A5A5);
    // back-to-back loads
    do_cycle(0, 1, 1, 32'h0000_0014, 32'h0BAD_F00D, 24'hA5A5A5);
    do_cycle(0, 1, 0, 32'h0000_0010, 32'h0, 24'hA5A5A5);
    do_cycle(0, 1, 0, 32'h0000_0010, 32'h0, 24'hA5A5A5);
    do_cycle(0, 1, 0, 32'h0000_0014, 32'h0, 24'hA5A5A5);
    do_cycle(0, 1, 0, 32'h0000_0014, 32'h0, 24'hA5A5A5);
    // reset mid-load
    do_cycle(0, 1, 0, 32'h0000_0010, 32'h0, 24'hA5A5A5);
    do_cycle(1, 1, 0, 32'h0000_0010, 32'h0, 24'hA5A5A5);
    do_cycle(0, 0, 0, 32'h0, 32'h0, 24'hA5A5A5);
    do_cycle(0, 1, 0, PB | 32'h100, 32'h0, 24'hA5A5A5);

    // randomized traffic
    cur_sw = 24'h0;
    p_rd = 0; p_wr = 0; p_a = 0; p_wd = 0;
    for (int n = 0; n < 600; n++) begin
      int op;
      logic r;
      if ($urandom_range(0, 7) == 0) cur_sw = 24'($urandom);
      r = ($urandom_range(0, 39) == 0);
      if (m_pending && $urandom_range(0, 3) != 0) begin
        do_cycle(r, p_rd, p_wr, p_a, p_wd, cur_sw);
      end else begin
        op = $urandom_range(0, 9);
        p_wd = $urandom;
        case (op)
          0:       begin p_rd = 0; p_wr = 0; p_a = $urandom; end
          1, 2:    begin p_rd = 1; p_wr = 0; p_a = dram_a($urandom_range(0, 15)); end
          3, 4:    begin p_rd = 1; p_wr = 1; p_a = dram_a($urandom_range(0, 15)); end
          5:       begin p_rd = 1; p_wr = 1; p_a = PB | 32'($urandom_range(0, 3)); end
          6:       begin p_rd = $urandom_range(0, 1); p_wr = 1; p_a = PB | 32'h060; end
          7:       begin p_rd = 1; p_wr = 0; p_a = PB | 32'h070 | 32'($urandom_range(0, 3)); end
          8:       begin p_rd = 1; p_wr = $urandom_range(0, 1); p_a = PB | 32'($urandom_range(0, 4095)); end
          default: begin p_rd = 1; p_wr = 0; p_a = dram_a($urandom_range(0, 15)); r = 1'b1; end
        endcase
        do_cycle(r, p_rd, p_wr, p_a, p_wd, cur_sw);
      end
    end

    do_cycle(0, 0, 0, 32'h0, 32'h0, cur_sw);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending expectations act=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
